// File: rtl/comparator_scan_ctrl.sv
// Steps the comparator select through codes 0..3 and captures K/L into maps.
// Optional expected-map check enabled by COMPARATOR_SCAN_CHECK_EN.
module comparator_scan_ctrl #(
  parameter int         DWELL = 2,
  parameter int         CNT_W = 4,
  parameter logic [3:0] EXP_K = 4'b0000,
  parameter logic [3:0] EXP_L = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       K,
  input  logic       L,
  output logic [1:0] s,
  output logic       busy,
  output logic       done,
  output logic [3:0] k_map,
  output logic [3:0] l_map,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CAP = CNT_W'(DWELL - 1);

  state_t           state;
  state_t           nxt;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             cap;
  logic             last;

  assign cap  = (state == DRIVE) && (cnt == CAP);
  assign last = cap && (idx == 2'd3);
  assign s    = idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nxt = DRIVE;
      end
      DRIVE: begin
        busy = 1'b1;
        if (last) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // idx drops back to 0 on the final capture so s reads 0 in DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= 2'd0;
      cnt   <= '0;
      k_map <= 4'b0000;
      l_map <= 4'b0000;
    end else begin
      if (state == IDLE && start) begin
        idx   <= 2'd0;
        cnt   <= '0;
        k_map <= 4'b0000;
        l_map <= 4'b0000;
      end else if (cap) begin
        k_map[idx] <= K;
        l_map[idx] <= L;
        cnt        <= '0;
        idx        <= last ? 2'd0 : idx + 2'd1;
      end else if (state == DRIVE) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef COMPARATOR_SCAN_CHECK_EN
  logic [3:0] k_fin;
  logic [3:0] l_fin;

  // Maps as they will read in DONE, including the bit captured now
  always_comb begin
    k_fin      = k_map;
    l_fin      = l_map;
    k_fin[idx] = K;
    l_fin[idx] = L;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (state == IDLE && start) begin
      err <= 1'b0;
    end else if (last) begin
      err <= err | ({k_fin, l_fin} != {EXP_K, EXP_L});
    end
  end
`else
  assign err = |({EXP_K, EXP_L} & 8'h00);
`endif

endmodule

// File: tb/tb_comparator_scan_ctrl.sv
// Directed bench for comparator_scan_ctrl: vector table plus
// reset, DWELL=1 and mismatch-flag sequences.
module tb_comparator_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       start1;
  logic       lflip;
  logic       K, L, K1, L1;
  logic [1:0] s, s1;
  logic       busy, done, busy1, done1;
  logic [3:0] k_map, l_map, k_map1, l_map1;
  logic       err, err1;
  logic [3:0] kt = 4'b1101;
  logic [3:0] lt = 4'b1011;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef COMPARATOR_SCAN_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  assign K  = kt[s];
  assign L  = lt[s] ^ (lflip && s == 2'd2);
  assign K1 = kt[s1];
  assign L1 = lt[s1];

  comparator_scan_ctrl #(
    .DWELL(2), .CNT_W(4),
    .EXP_K(4'b1101), .EXP_L(4'b1011)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .K(K), .L(L), .s(s), .busy(busy), .done(done),
    .k_map(k_map), .l_map(l_map), .err(err)
  );

  comparator_scan_ctrl #(
    .DWELL(1), .CNT_W(2),
    .EXP_K(4'b1101), .EXP_L(4'b1011)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .K(K1), .L(L1), .s(s1), .busy(busy1), .done(done1),
    .k_map(k_map1), .l_map(l_map1), .err(err1)
  );

  typedef struct {
    logic       start;
    logic [1:0] s;
    logic       busy;
    logic       done;
    logic [3:0] k;
    logic [3:0] l;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic st, logic [1:0] es, logic eb,
                              logic ed, logic [3:0] ek, logic [3:0] el);
    vec_t v;
    v.start = st; v.s = es; v.busy = eb;
    v.done = ed; v.k = ek; v.l = el;
    return v;
  endfunction

  task automatic cmp(string nm, logic [12:0] act, logic [12:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got s/b/d/k/l/e=%b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk(string nm, logic [1:0] es, logic eb, logic ed,
                     logic [3:0] ek, logic [3:0] el, logic ee);
    cmp(nm, {s, busy, done, k_map, l_map, err},
            {es, eb, ed, ek, el, ee});
  endtask

  task automatic chk1(string nm, logic [1:0] es, logic eb, logic ed,
                      logic [3:0] ek, logic [3:0] el);
    cmp(nm, {s1, busy1, done1, k_map1, l_map1, err1},
            {es, eb, ed, ek, el, 1'b0});
  endtask

  task automatic run_tbl(string nm, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d]", nm, i), tbl[i].s, tbl[i].busy,
          tbl[i].done, tbl[i].k, tbl[i].l, 1'b0);
      start = tbl[i].start;
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 4'b0000, 4'b0000);
    tbl[1]  = mk(1, 0, 1, 0, 4'b0000, 4'b0000);
    tbl[2]  = mk(1, 0, 1, 0, 4'b0000, 4'b0000);
    tbl[3]  = mk(1, 1, 1, 0, 4'b0001, 4'b0001);
    tbl[4]  = mk(1, 1, 1, 0, 4'b0001, 4'b0001);
    tbl[5]  = mk(1, 2, 1, 0, 4'b0001, 4'b0011);
    tbl[6]  = mk(1, 2, 1, 0, 4'b0001, 4'b0011);
    tbl[7]  = mk(1, 3, 1, 0, 4'b0101, 4'b0011);
    tbl[8]  = mk(1, 3, 1, 0, 4'b0101, 4'b0011);
    tbl[9]  = mk(1, 0, 0, 1, 4'b1101, 4'b1011);
    tbl[10] = mk(1, 0, 0, 0, 4'b1101, 4'b1011);
    tbl[11] = mk(0, 0, 1, 0, 4'b0000, 4'b0000);
    tbl[12] = mk(0, 0, 1, 0, 4'b0000, 4'b0000);
    tbl[13] = mk(0, 1, 1, 0, 4'b0001, 4'b0001);
    tbl[14] = mk(0, 1, 1, 0, 4'b0001, 4'b0001);
    tbl[15] = mk(0, 2, 1, 0, 4'b0001, 4'b0011);
    tbl[16] = mk(0, 2, 1, 0, 4'b0001, 4'b0011);
    tbl[17] = mk(0, 3, 1, 0, 4'b0101, 4'b0011);
    tbl[18] = mk(0, 3, 1, 0, 4'b0101, 4'b0011);
    tbl[19] = mk(0, 0, 0, 1, 4'b1101, 4'b1011);
    tbl[20] = mk(0, 0, 0, 0, 4'b1101, 4'b1011);

    reset_n = 1'b0;
    start   = 1'b0;
    start1  = 1'b0;
    lflip   = 1'b0;

    #3;
    chk("reset", 0, 0, 0, 4'b0000, 4'b0000, 1'b0);
    chk1("reset1", 0, 0, 0, 4'b0000, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle", 0, 0, 0, 4'b0000, 4'b0000, 1'b0);
    end

    // Full scan with start held through DONE, then a second scan
    run_tbl("scan", 21);

    // Reset in cycle 5 of a scan
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_c5", 2, 1, 0, 4'b0001, 4'b0011, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst", 0, 0, 0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_hold", 0, 0, 0, 4'b0000, 4'b0000, 1'b0);
    run_tbl("rescan", 10);
    @(negedge clk);
    start = 1'b0;
    chk("rescan_end", 0, 0, 0, 4'b1101, 4'b1011, 1'b0);
    @(negedge clk);
    chk("rescan_idle", 0, 0, 0, 4'b1101, 4'b1011, 1'b0);

    // DWELL=1 instance
    @(negedge clk);
    chk1("d1_c0", 0, 0, 0, 4'b0000, 4'b0000);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk1("d1_c1", 0, 1, 0, 4'b0000, 4'b0000);
    @(negedge clk);
    chk1("d1_c2", 1, 1, 0, 4'b0001, 4'b0001);
    @(negedge clk);
    chk1("d1_c3", 2, 1, 0, 4'b0001, 4'b0011);
    @(negedge clk);
    chk1("d1_c4", 3, 1, 0, 4'b0101, 4'b0011);
    @(negedge clk);
    chk1("d1_c5", 0, 0, 1, 4'b1101, 4'b1011);
    @(negedge clk);
    chk1("d1_c6", 0, 0, 0, 4'b1101, 4'b1011);

    // Mismatch: L flipped at s=2
    lflip = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("err_done", 0, 0, 1, 4'b1101, 4'b1111, EXP_ERR);
    @(negedge clk);
    chk("err_hold", 0, 0, 0, 4'b1101, 4'b1111, EXP_ERR);
    lflip = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_clr", 0, 1, 0, 4'b0000, 4'b0000, 1'b0);
    repeat (8) @(negedge clk);
    chk("ok_done", 0, 0, 1, 4'b1101, 4'b1011, 1'b0);
    @(negedge clk);
    chk("ok_idle", 0, 0, 0, 4'b1101, 4'b1011, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/comparator_scan_ctrl.md
# comparator_scan_ctrl

Scan controller for the 2-bit comparator stage. It drives the comparator's select input `s` through codes 0..3, holds each code for a programmable dwell, and captures the returned `K`/`L` bits into two 4-bit result maps. A `start`/`busy`/`done` handshake makes the comparator's full truth table available to the rest of the design as registered vectors.

## Interface
Parameters:
- `DWELL`, default 2: cycles each `s` code is held before K/L are captured; legal range 1..15.
- `CNT_W`, default 4: dwell counter width; must satisfy 2^CNT_W > DWELL.
- `EXP_K`, default 4'b0000: expected K map, bit i = expected K at s=i. Used only with the check macro.
- `EXP_L`, default 4'b0000: expected L map, same layout. Used only with the check macro.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: scan request; sampled only in IDLE.
- `K` input 1: comparator output K.
- `L` input 1: comparator output L.
- `s` output 2: select code driven to the comparator.
- `busy` output 1: high while a scan is in progress.
- `done` output 1: one-cycle pulse when a scan completes.
- `k_map` output 4: captured K values, bit i = K at s=i.
- `l_map` output 4: captured L values, bit i = L at s=i.
- `err` output 1: sticky mismatch flag; tied 0 when the check macro is not defined.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE: `s`=0, `busy`=0. When `start`=1:
  - clear `k_map`, `l_map` and `err`;
  - set idx=0 and dwell counter cnt=0;
  - go to DRIVE.
- DRIVE: `s`=idx, `busy`=1; cnt increments each cycle.
  - On the edge where cnt==DWELL-1: `k_map[idx]`<=K, `l_map[idx]`<=L, cnt<=0.
  - After that capture: if idx==3, go to DONE; otherwise idx<=idx+1.
- DONE: `done`=1 and `busy`=0 for exactly one cycle; `s` returns to 0; next state IDLE.
- `start` is ignored in DRIVE and DONE; there is no queuing.
- `s` is registered and changes only on clock edges, so it is glitch-free toward the comparator.
- idx is 2 bits. Termination is detected by idx==3 at capture, so idx never wraps.
- `k_map`/`l_map` hold their values after DONE until the next accepted `start`.
- Reset (asynchronous, at any time, including mid-scan): state IDLE, `s`=0, `busy`=0, `done`=0, `k_map`=0, `l_map`=0, `err`=0, idx=0, cnt=0. Any partial scan is discarded.

## Timing
- Cycle 0: IDLE with `start`=1.
- Cycles 1..4·DWELL: `busy`=1. `s`=i during cycles i·DWELL+1 .. (i+1)·DWELL.
- Capture edge for code i: end of cycle (i+1)·DWELL. K/L must be valid in that cycle; the comparator is combinational, so a 1-cycle settle is inherent.
- Cycle 4·DWELL+1: `done`=1, `busy`=0. Maps are final in this cycle.
- Earliest next accepted `start`: cycle 4·DWELL+2.
- Latency from `start` to `done`: 4·DWELL+1 cycles.
- DWELL=1: `s` changes every cycle, with capture on every edge.

## Configuration
- Macro: `COMPARATOR_SCAN_CHECK_EN`.
- Defined: in the DONE cycle, `err` is set if {k_map,l_map} != {EXP_K,EXP_L}. `err` stays set until the next accepted `start` or reset. K/L captured at the DONE edge use the final map values.
- Not defined: `err` is constant 0; `EXP_K` and `EXP_L` are unused; no compare logic is present.

## Test plan
- Reset, DWELL=2: `reset_n` low → all outputs 0. Release, no `start` → outputs stay 0 for 20 cycles.
- Full scan, DWELL=2, bench models K = table 4'b1101, L = table 4'b1011 indexed by `s`:
  - `s` sequence 0,0,1,1,2,2,3,3 over cycles 1–8;
  - `done` in cycle 9;
  - `k_map`=4'b1101, `l_map`=4'b1011.
- `start` held high throughout the scan → exactly one scan, one `done` pulse. A new scan begins at cycle 10 with the maps cleared.
- Reset asserted in cycle 5 of a scan → `s`, `busy`, maps return to 0 immediately. A new `start` gives a complete, correct 8-cycle scan.
- DWELL=1 → `s`=0,1,2,3 in cycles 1–4, `done` in cycle 5.
- Check macro defined, EXP_K=4'b1101, EXP_L=4'b1011:
  - matching model → `err`=0;
  - flip L at s=2 → `err`=1 from the DONE cycle;
  - `err` clears on the next accepted `start`.
